// File: rtl/hmmm_core.sv
// hmmm_core: multicycle 16-bit-instruction processor with one request/ready memory port.
// Define HMMM_CORE_TRACE_EN to add the retire_valid/retire_pc trace outputs.
module hmmm_core #(
    parameter int WIDTH  = 8,
    parameter int NREGS  = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_ready,
`ifdef HMMM_CORE_TRACE_EN
    output logic              retire_valid,
    output logic [ADDR_W-1:0] retire_pc,
`endif
    output logic              halted
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;
    localparam int RIDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

    function automatic logic [RIDX_W-1:0] reg_idx(input logic [3:0] f);
        return RIDX_W'({1'b0, f} % 5'(NREGS));
    endfunction

    function automatic logic [WIDTH-1:0] sext8(input logic [7:0] v);
        return WIDTH'($signed(v));
    endfunction

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, pc_inc_s;
    logic [15:0]       ir_q, ir_d;
    logic [WIDTH-1:0]  opx_q, opx_d, opy_q, opy_d, opz_q, opz_d, ld_q, ld_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic              we_q, we_d, halted_q, halted_d;
    logic [WIDTH-1:0]  wdata_q, wdata_d;
    logic [WIDTH-1:0]  regs_q [NREGS];
    logic [RIDX_W-1:0] x_idx_s, y_idx_s, z_idx_s;
    logic [WIDTH-1:0]  rx_s, ry_s, rz_s, wr_data_s;
    logic              wr_en_s, mem_op_s;
    logic [3:0]        op_s;
    logic [7:0]        imm_s;

    assign op_s     = ir_q[15:12];
    assign imm_s    = ir_q[7:0];
    assign mem_op_s = (op_s >= 4'h6) && (op_s <= 4'h9);
    assign pc_inc_s = pc_q + ADDR_W'(1'b1);
    assign x_idx_s  = reg_idx(ir_q[11:8]);
    assign y_idx_s  = reg_idx(ir_q[7:4]);
    assign z_idx_s  = reg_idx(ir_q[3:0]);
    assign rx_s = (x_idx_s == {RIDX_W{1'b0}}) ? {WIDTH{1'b0}} : regs_q[x_idx_s];
    assign ry_s = (y_idx_s == {RIDX_W{1'b0}}) ? {WIDTH{1'b0}} : regs_q[y_idx_s];
    assign rz_s = (z_idx_s == {RIDX_W{1'b0}}) ? {WIDTH{1'b0}} : regs_q[z_idx_s];

    // Next-state, PC, register-write and bus-register logic
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        opx_d     = opx_q;
        opy_d     = opy_q;
        opz_d     = opz_q;
        ld_d      = ld_q;
        adr_d     = adr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        halted_d  = halted_q;
        wr_en_s   = 1'b0;
        wr_data_s = {WIDTH{1'b0}};
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                opx_d   = rx_s;
                opy_d   = ry_s;
                opz_d   = rz_s;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = pc_inc_s;
                case (op_s)
                    4'h0: begin
                        state_d  = S_HALT;
                        pc_d     = pc_q;
                        halted_d = 1'b1;
                    end
                    4'h1: begin wr_en_s = 1'b1; wr_data_s = sext8(imm_s); end
                    4'h2: begin wr_en_s = 1'b1; wr_data_s = opx_q + sext8(imm_s); end
                    4'h3: begin wr_en_s = 1'b1; wr_data_s = opy_q; end
                    4'h4: begin wr_en_s = 1'b1; wr_data_s = opy_q + opz_q; end
                    4'h5: begin wr_en_s = 1'b1; wr_data_s = opy_q - opz_q; end
                    4'h6, 4'h7, 4'h8, 4'h9: begin
                        state_d = S_MEM;
                        pc_d    = pc_q;
                    end
                    4'hA: pc_d = ADDR_W'(imm_s);
                    4'hB: pc_d = ADDR_W'(opx_q);
                    4'hC: pc_d = (opx_q == {WIDTH{1'b0}}) ? ADDR_W'(imm_s) : pc_inc_s;
                    4'hD: pc_d = (opx_q != {WIDTH{1'b0}}) ? ADDR_W'(imm_s) : pc_inc_s;
                    4'hE: pc_d = (!opx_q[WIDTH-1] && (opx_q != {WIDTH{1'b0}})) ? ADDR_W'(imm_s) : pc_inc_s;
                    4'hF: pc_d = opx_q[WIDTH-1] ? ADDR_W'(imm_s) : pc_inc_s;
                    default: pc_d = pc_inc_s;
                endcase
            end
            S_MEM: begin
                // Odd opcodes in the memory group (7, 9) are the stores
                if (mem_ready) begin
                    if (op_s[0]) begin
                        state_d = S_FETCH;
                        pc_d    = pc_inc_s;
                    end else begin
                        ld_d    = mem_rdata[WIDTH-1:0];
                        state_d = S_WB;
                    end
                end else begin
                    state_d = S_MEM;
                end
            end
            S_WB: begin
                wr_en_s   = 1'b1;
                wr_data_s = ld_q;
                pc_d      = pc_inc_s;
                state_d   = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase

        if (state_d == S_FETCH) begin
            adr_d = pc_d;
            we_d  = 1'b0;
        end else if ((state_q == S_EXEC) && (state_d == S_MEM)) begin
            adr_d   = op_s[3] ? ADDR_W'(opy_q) : ADDR_W'(imm_s);
            we_d    = op_s[0];
            wdata_d = opx_q;
        end else begin
            adr_d = adr_q;
        end
    end

    // Control, datapath latches and bus-output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_FETCH;
            pc_q     <= {ADDR_W{1'b0}};
            ir_q     <= 16'h0000;
            opx_q    <= {WIDTH{1'b0}};
            opy_q    <= {WIDTH{1'b0}};
            opz_q    <= {WIDTH{1'b0}};
            ld_q     <= {WIDTH{1'b0}};
            adr_q    <= {ADDR_W{1'b0}};
            we_q     <= 1'b0;
            wdata_q  <= {WIDTH{1'b0}};
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            opx_q    <= opx_d;
            opy_q    <= opy_d;
            opz_q    <= opz_d;
            ld_q     <= ld_d;
            adr_q    <= adr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            halted_q <= halted_d;
        end
    end

    // Register file; r0 is never written so it stays zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= {WIDTH{1'b0}};
            end
        end else if (wr_en_s && (x_idx_s != {RIDX_W{1'b0}})) begin
            regs_q[x_idx_s] <= wr_data_s;
        end
    end

    // Gating with reset withdraws a pending request the moment reset asserts
    assign mem_req   = reset & ((state_q == S_FETCH) | (state_q == S_MEM));
    assign mem_we    = we_q;
    assign mem_adr   = adr_q;
    assign mem_wdata = wdata_q;
    assign halted    = halted_q;

`ifdef HMMM_CORE_TRACE_EN
    assign retire_valid = ((state_q == S_EXEC) && !mem_op_s) ||
                          ((state_q == S_MEM) && mem_ready && op_s[0]) ||
                          (state_q == S_WB);
    assign retire_pc    = pc_q;
`endif
endmodule

// File: tb/tb_hmmm_core.sv
// Self-checking bench for hmmm_core: directed programs plus random programs checked
// against an instruction-level interpreter of the ISA (bus transactions, cycle count).
module tb_hmmm_core;
    logic        clk, reset, mem_req, mem_we, mem_ready, halted;
    logic [7:0]  mem_adr, mem_wdata;
    logic [15:0] mem_rdata;
`ifdef HMMM_CORE_TRACE_EN
    logic        retire_valid;
    logic [7:0]  retire_pc;
`endif

    typedef struct { bit we; int adr; int data; } txn_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] mem  [256];
    int          mmem [256];
    txn_t        exp_q [$];
    int          exp_ret [$];
    int          exp_cyc;

    hmmm_core dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
        .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
`ifdef HMMM_CORE_TRACE_EN
        .retire_valid(retire_valid), .retire_pc(retire_pc),
`endif
        .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] enc3(input int op, input int x, input int y, input int z);
        return 16'((op << 12) | (x << 8) | (y << 4) | z);
    endfunction

    function automatic logic [15:0] enci(input int op, input int x, input int imm);
        return 16'((op << 12) | (x << 8) | (imm & 255));
    endfunction

    task automatic put(input int a, input logic [15:0] w);
        mem[a]  = w;
        mmem[a] = int'(w);
    endtask

    task automatic clear_mem();
        logic [31:0] v;
        for (int a = 0; a < 256; a++) begin
            v = $urandom;
            put(a, v[15:0]);
        end
    endtask

    // ISA interpreter: expected bus transactions, retire addresses and cycle count
    task automatic model_run();
        int r [16];
        int pc, nxt, ins, op, x, y, z, imm, vx, vy, vz, v, a;
        bit done, wr;
        txn_t t;
        exp_q.delete();
        exp_ret.delete();
        exp_cyc = 0;
        done = 1'b0;
        pc = 0;
        foreach (r[i]) r[i] = 0;
        for (int n = 0; n < 500 && !done; n++) begin
            t.we = 1'b0; t.adr = pc; t.data = 0;
            exp_q.push_back(t);
            exp_ret.push_back(pc);
            ins = mmem[pc];
            op = (ins >> 12) & 15; x = (ins >> 8) & 15; y = (ins >> 4) & 15; z = ins & 15;
            imm = ins & 255;
            vx = r[x]; vy = r[y]; vz = r[z];
            nxt = (pc + 1) % 256;
            exp_cyc += 3;
            wr = 1'b1;
            v = 0;
            case (op)
                0: begin done = 1'b1; wr = 1'b0; end
                1: v = imm;
                2: v = vx + imm;
                3: v = vy;
                4: v = vy + vz;
                5: v = vy - vz;
                6, 8: begin
                    a = (op == 6) ? imm : vy;
                    t.we = 1'b0; t.adr = a; t.data = 0;
                    exp_q.push_back(t);
                    v = mmem[a] & 255;
                    exp_cyc += 2;
                end
                7, 9: begin
                    a = (op == 7) ? imm : vy;
                    t.we = 1'b1; t.adr = a; t.data = vx;
                    exp_q.push_back(t);
                    mmem[a] = vx;
                    exp_cyc += 1;
                    wr = 1'b0;
                end
                10: begin nxt = imm; wr = 1'b0; end
                11: begin nxt = vx; wr = 1'b0; end
                12: begin if (vx == 0) nxt = imm; wr = 1'b0; end
                13: begin if (vx != 0) nxt = imm; wr = 1'b0; end
                14: begin if (vx != 0 && vx < 128) nxt = imm; wr = 1'b0; end
                default: begin if (vx >= 128) nxt = imm; wr = 1'b0; end
            endcase
            if (wr && x != 0) r[x] = v & 255;
            pc = nxt;
        end
    endtask

    // Runs the loaded program on the DUT, acting as memory, checking each bus event
    task automatic run_program(input int pct, input int fixed_w, input bit do_reset, output int edges);
        int waits, wcnt;
        bit rdy, pend, acc_rd;
        logic [7:0] p_adr, p_wd;
        logic p_we;
        txn_t e;
        model_run();
        mem_ready = 1'b0;
        if (do_reset) begin
            reset = 1'b0;
            repeat (2) @(negedge clk);
        end else begin
            @(negedge clk);
        end
        reset = 1'b1;
        edges = 0; waits = 0; wcnt = 0; pend = 1'b0; acc_rd = 1'b0;
        p_adr = 8'h00; p_wd = 8'h00; p_we = 1'b0;
        while (!halted && edges < 3000) begin
            if (fixed_w >= 0) rdy = (wcnt >= fixed_w);
            else rdy = ($urandom_range(99) < pct);
            mem_ready = rdy;
            mem_rdata = mem[mem_adr];
            #1;
            if (pend) begin
                n_checks++;
                if (mem_req !== 1'b1 || mem_adr !== p_adr || mem_we !== p_we || (p_we && mem_wdata !== p_wd))
                    $display("FAIL hold_stable: req=%b adr=%h we=%b wd=%h, required req=1 adr=%h we=%b wd=%h",
                             mem_req, mem_adr, mem_we, mem_wdata, p_adr, p_we, p_wd);
                else n_pass++;
            end
            if (acc_rd) begin
                n_checks++;
                if (mem_req !== 1'b0) $display("FAIL req_drop: mem_req=%b, required 0", mem_req);
                else n_pass++;
            end
            pend = 1'b0; acc_rd = 1'b0;
            if (mem_req === 1'b1) begin
                if (rdy) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL txn_extra: adr=%h we=%b, required no transfer", mem_adr, mem_we);
                    end else begin
                        e = exp_q.pop_front();
                        if (mem_we !== e.we || 32'(mem_adr) !== e.adr || (e.we && 32'(mem_wdata) !== e.data))
                            $display("FAIL txn: we=%b adr=%h wd=%h, required we=%b adr=%h wd=%h",
                                     mem_we, mem_adr, mem_wdata, e.we, e.adr, e.data);
                        else n_pass++;
                    end
                    if (mem_we) mem[mem_adr] = {8'h00, mem_wdata};
                    acc_rd = !mem_we;
                    wcnt = 0;
                end else begin
                    waits++; wcnt++; pend = 1'b1;
                    p_adr = mem_adr; p_we = mem_we; p_wd = mem_wdata;
                end
            end
`ifdef HMMM_CORE_TRACE_EN
            if (retire_valid === 1'b1) begin
                n_checks++;
                if (exp_ret.size() == 0) $display("FAIL retire_extra: retire_pc=%h, required none", retire_pc);
                else if (32'(retire_pc) !== exp_ret[0]) $display("FAIL retire_pc: %h, required %h", retire_pc, exp_ret[0]);
                else n_pass++;
                if (exp_ret.size() != 0) void'(exp_ret.pop_front());
            end
`endif
            @(posedge clk);
            @(negedge clk);
            edges++;
        end
        n_checks++;
        if (halted !== 1'b1) $display("FAIL halt_reached: halted=%b after %0d cycles, required 1", halted, edges);
        else n_pass++;
        n_checks++;
        if (edges != exp_cyc + waits) $display("FAIL latency: %0d cycles, required %0d", edges, exp_cyc + waits);
        else n_pass++;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL txn_missing: %0d transfers outstanding, required 0", exp_q.size());
        else n_pass++;
`ifdef HMMM_CORE_TRACE_EN
        n_checks++;
        if (exp_ret.size() != 0) $display("FAIL retire_missing: %0d outstanding, required 0", exp_ret.size());
        else n_pass++;
`endif
    endtask

    task automatic test_reset();
        reset = 1'b0; mem_ready = 1'b0; mem_rdata = 16'h0000;
        @(negedge clk);
        n_checks++;
        if ({mem_req, mem_we, halted} !== 3'b000) $display("FAIL reset_ctl: req/we/halted=%b, required 000", {mem_req, mem_we, halted});
        else n_pass++;
        n_checks++;
        if ({mem_adr, mem_wdata} !== 16'h0000) $display("FAIL reset_bus: adr=%h wd=%h, required 00 00", mem_adr, mem_wdata);
        else n_pass++;
        reset = 1'b1;
        #1;
        n_checks++;
        if (mem_req !== 1'b1 || mem_adr !== 8'h00) $display("FAIL first_fetch: req=%b adr=%h, required 1 00", mem_req, mem_adr);
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_halt_timing();
        int edges;
        clear_mem();
        put(0, enci(1, 1, 5)); put(1, enci(1, 2, -3)); put(2, enc3(4, 3, 1, 2)); put(3, enci(0, 0, 0));
        run_program(100, -1, 1'b1, edges);
        n_checks++;
        if (edges != 12) $display("FAIL halt_cycle: halted at %0d, required 12", edges);
        else n_pass++;
    endtask

    task automatic test_arith();
        int edges;
        clear_mem();
        put(0, enci(1, 1, 5)); put(1, enci(1, 2, -3)); put(2, enc3(4, 3, 1, 2));
        put(3, enci(7, 3, 8'h60)); put(4, enci(2, 3, -1)); put(5, enci(7, 3, 8'h61)); put(6, enci(0, 0, 0));
        run_program(50, -1, 1'b1, edges);
        n_checks++;
        if (mem[8'h60] !== 16'd2 || mem[8'h61] !== 16'd1)
            $display("FAIL arith: M60=%h M61=%h, required 0002 0001", mem[8'h60], mem[8'h61]);
        else n_pass++;
    endtask

    task automatic test_store_load_waits();
        int edges;
        clear_mem();
        put(0, enci(1, 1, 7)); put(1, enci(7, 1, 8'h40)); put(2, enci(6, 4, 8'h40));
        put(3, enci(7, 4, 8'h41)); put(4, enci(0, 0, 0));
        run_program(0, 2, 1'b1, edges);
        n_checks++;
        if (mem[8'h40] !== 16'd7 || mem[8'h41] !== 16'd7)
            $display("FAIL store_load: M40=%h M41=%h, required 0007 0007", mem[8'h40], mem[8'h41]);
        else n_pass++;
    endtask

    task automatic test_branch();
        int edges;
        clear_mem();
        put(0, enci(1, 1, 0)); put(1, enci(12, 1, 8'h10)); put(2, enci(0, 0, 0));
        put(8'h10, enci(1, 2, -1)); put(8'h11, enci(14, 2, 8'h20)); put(8'h12, enci(7, 2, 8'h60));
        put(8'h13, enci(0, 0, 0)); put(8'h20, enci(0, 0, 0));
        run_program(100, -1, 1'b1, edges);
        n_checks++;
        if (mem[8'h60] !== 16'h00FF) $display("FAIL branch: M60=%h, required 00ff", mem[8'h60]);
        else n_pass++;
    endtask

    task automatic test_r0_and_wrap();
        int edges;
        clear_mem();
        put(0, enci(12, 6, 8'hF0)); put(1, enci(7, 7, 8'h62)); put(2, enci(0, 0, 0));
        put(8'hF0, enci(1, 6, 1)); put(8'hF1, enci(1, 0, 9)); put(8'hF2, enc3(4, 5, 0, 0));
        put(8'hF3, enci(7, 5, 8'h60)); put(8'hF4, enci(10, 0, 8'hFF)); put(8'hFF, enci(1, 7, 3));
        run_program(70, -1, 1'b1, edges);
        n_checks++;
        if (mem[8'h60] !== 16'h0000 || mem[8'h62] !== 16'h0003)
            $display("FAIL r0_wrap: M60=%h M62=%h, required 0000 0003", mem[8'h60], mem[8'h62]);
        else n_pass++;
    endtask

    task automatic test_reg_indirect();
        int edges;
        clear_mem();
        put(0, enci(1, 1, 8'h50)); put(1, enci(1, 2, 8'h33)); put(2, enc3(9, 2, 1, 0));
        put(3, enc3(8, 3, 1, 0)); put(4, enci(1, 4, 7)); put(5, enci(11, 4, 0)); put(6, enci(0, 0, 0));
        put(7, enc3(5, 5, 3, 2)); put(8, enc3(3, 6, 3, 0)); put(9, enci(7, 6, 8'h61));
        put(10, enci(7, 5, 8'h62)); put(11, enci(0, 0, 0));
        run_program(60, -1, 1'b1, edges);
        n_checks++;
        if (mem[8'h61] !== 16'h0033 || mem[8'h62] !== 16'h0000)
            $display("FAIL reg_indirect: M61=%h M62=%h, required 0033 0000", mem[8'h61], mem[8'h62]);
        else n_pass++;
    endtask

    task automatic test_reset_mid_mem();
        int edges, seen;
        logic [15:0] m40;
        clear_mem();
        put(0, enci(1, 1, 7)); put(1, enci(7, 1, 8'h40)); put(2, enci(0, 0, 0));
        m40 = mem[8'h40];
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        seen = 0;
        for (int c = 0; c < 40 && seen < 2; c++) begin
            mem_ready = !(mem_req && mem_we);
            mem_rdata = mem[mem_adr];
            #1;
            if (mem_req && mem_we) seen++;
            if (seen < 2) begin
                @(posedge clk);
                @(negedge clk);
            end
        end
        n_checks++;
        if (seen < 2) $display("FAIL reach_mem: store request seen %0d times, required 2", seen);
        else n_pass++;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({mem_req, mem_we, mem_adr} !== 10'h000) $display("FAIL reset_mid_mem: req=%b we=%b adr=%h, required 0 0 00", mem_req, mem_we, mem_adr);
        else n_pass++;
        put(0, enci(7, 1, 8'h41)); put(1, enci(0, 0, 0));
        run_program(100, -1, 1'b0, edges);
        n_checks++;
        if (mem[8'h40] !== m40 || mem[8'h41] !== 16'h0000)
            $display("FAIL abandon: M40=%h M41=%h, required %h 0000", mem[8'h40], mem[8'h41], m40);
        else n_pass++;
    endtask

    task automatic test_random();
        int ops [13] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 12, 13, 14, 15};
        int pcts [3] = '{100, 60, 30};
        int op, x, y, z, imm, edges;
        for (int it = 0; it < 3; it++) begin
            clear_mem();
            for (int i = 0; i < 24; i++) begin
                op = ops[$urandom_range(12)];
                x = $urandom_range(15); y = $urandom_range(15); z = $urandom_range(15);
                imm = $urandom_range(255);
                if (op == 9) op = 7;
                if (op == 6 || op == 7) imm = 128 + $urandom_range(63);
                if (op >= 12) imm = i + 1 + $urandom_range(3);
                if (op >= 3 && op <= 5) put(i, enc3(op, x, y, z));
                else if (op == 8) put(i, enc3(op, x, y, 0));
                else put(i, enci(op, x, imm));
            end
            for (int k = 1; k < 16; k++) put(23 + k, enci(7, k, 8'hE0 + k));
            put(39, enci(0, 0, 0));
            run_program(pcts[it], -1, 1'b1, edges);
        end
    endtask

    initial begin
        reset = 1'b0; mem_ready = 1'b0; mem_rdata = 16'h0000;
        test_reset();
        test_halt_timing();
        test_arith();
        test_store_load_waits();
        test_branch();
        test_r0_and_wrap();
        test_reg_indirect();
        test_reset_mid_mem();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
